// File: rtl/register_file.sv
// Multi-port register file: two combinational read ports, one synchronous write port.
// Register 0 always reads zero; optional same-cycle write-to-read forwarding.
module register_file #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 5,
    parameter int BYPASS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] ra1,
    input  logic [ADDR_BITS-1:0] ra2,
    input  logic [ADDR_BITS-1:0] wa,
    input  logic [WIDTH-1:0]     wd,
    input  logic                 we,
    output logic [WIDTH-1:0]     rd1,
    output logic [WIDTH-1:0]     rd2
);

    localparam int NREGS = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [NREGS];
    logic             wr_valid;

    // Address 0 is never written, so the write qualifier already excludes it.
    assign wr_valid = (we == 1'b1) && (wa != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_valid) begin
            mem[wa] <= wd;
        end
    end

    // Reset and address 0 both force a zero read, taking priority over forwarding.
    always_comb begin
        rd1 = '0;
        if (!reset && (ra1 != '0)) begin
            if ((BYPASS != 0) && wr_valid && (ra1 == wa)) begin
                rd1 = wd;
            end else begin
                rd1 = mem[ra1];
            end
        end
    end

    always_comb begin
        rd2 = '0;
        if (!reset && (ra2 != '0)) begin
            if ((BYPASS != 0) && wr_valid && (ra2 == wa)) begin
                rd2 = wd;
            end else begin
                rd2 = mem[ra2];
            end
        end
    end

endmodule
